// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment decode table and the display word shared by the scanner
package seven_seg_pkg;
   localparam int MAX_DIGITS = 8;
   localparam logic [6:0] SEG_OFF = 7'h00;
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   typedef struct packed {
      logic [4*MAX_DIGITS-1:0] value;
      logic [MAX_DIGITS-1:0]   dp;
      logic                    blank_lz;
   } display_word_t;
endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// hex_to_7seg: nibble to active-high a..g segment pattern
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed hex display paced by an external scan clock; values swap only at frame boundaries
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int   NUM_DIGITS     = 4,
   parameter logic SEG_ACTIVE_LOW = 1'b1,
   parameter logic AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    scan_clk_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    blank_lz_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic                    frame_o
);
   localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   logic [2:0] sync;
   logic [DW-1:0] digit;
   logic tick, wrap, pending, active, blank, dot;
   logic [MAX_DIGITS-1:0] lz;
   logic [NUM_DIGITS-1:0] one_hot;
   logic [3:0] nib;
   logic [6:0] glyph, pattern;
   display_word_t disp, pend, in_word;
   assign tick = sync[1] & ~sync[2];
   assign wrap = digit == DW'(NUM_DIGITS - 1);
   assign ready_o = ~pending;
   assign pattern = blank ? SEG_OFF : glyph;
   hex_to_7seg u_dec (.nib(nib), .seg(glyph));
   always_comb begin
      in_word = '0;
      in_word.value[4*NUM_DIGITS-1:0] = value_i;
      in_word.dp[NUM_DIGITS-1:0] = dp_i;
      in_word.blank_lz = blank_lz_i;
   end
   // lz[k]: nibbles k..top are all zero; unused upper nibbles stay zero so the chain is unaffected
   always_comb begin
      lz = '0;
      nib = '0;
      dot = 1'b0;
      blank = 1'b0;
      one_hot = '0;
      lz[MAX_DIGITS-1] = disp.value[4*MAX_DIGITS-1 -: 4] == 4'h0;
      for (int k = MAX_DIGITS - 2; k >= 0; k--) lz[k] = lz[k+1] & (disp.value[4*k +: 4] == 4'h0);
      for (int k = 0; k < MAX_DIGITS; k++)
         if (int'(digit) == k) begin
            nib = disp.value[4*k +: 4];
            dot = disp.dp[k];
            blank = disp.blank_lz & lz[k] & (k != 0);
         end
      for (int k = 0; k < NUM_DIGITS; k++) one_hot[k] = int'(digit) == k;
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync <= '0;
         digit <= '0;
         active <= 1'b0;
         pending <= 1'b0;
         disp <= '0;
         pend <= '0;
         frame_o <= 1'b0;
         an_o <= {NUM_DIGITS{AN_ACTIVE_LOW}};
         seg_o <= SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
         dp_o <= SEG_ACTIVE_LOW;
      end else begin
         sync <= {sync[1:0], scan_clk_i};
         frame_o <= tick & wrap;
         if (tick) begin
            digit <= wrap ? '0 : digit + DW'(1);
            active <= 1'b1;
         end
         if (tick & wrap & pending) begin
            disp <= pend;
            pending <= 1'b0;
         end else if (valid_i & ~pending) begin
            pend <= in_word;
            pending <= 1'b1;
         end
         an_o <= active ? one_hot ^ {NUM_DIGITS{AN_ACTIVE_LOW}} : {NUM_DIGITS{AN_ACTIVE_LOW}};
         seg_o <= (active ? pattern : SEG_OFF) ^ {7{SEG_ACTIVE_LOW}};
         dp_o <= (active & dot) ^ SEG_ACTIVE_LOW;
      end
   end
endmodule
